layer_mac_sched: RTL and testbench

- Time-multiplexed sequencer that computes one fully-connected layer of ReLU neurons using a single shared float_mult and float_adder.
- Replaces per-node parallel multiplier/adder trees when area matters.
- Reads activations and weights from external synchronous memories, accumulates the dot product plus bias, and applies ReLU.
- Emits one registered result per neuron with index, then signals done.

---
 rtl/layer_mac_sched_pkg.sv | 21 ++
 rtl/layer_mac_fsm.sv | 134 +++++++++++++
 rtl/layer_mac_sched.sv | 136 +++++++++++++
 tb/tb_layer_mac_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_mac_sched_pkg.sv
// Shared constants and helpers for the time-multiplexed fully-connected layer sequencer.
package layer_mac_sched_pkg;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Sign-bit ReLU: -0.0 and negative NaN/Inf also clamp to +0.0.
    function automatic logic [31:0] relu_f32(input logic [31:0] v);
        logic [31:0] r;
        if (v[31]) begin
            r = FP_ZERO;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/layer_mac_fsm.sv
// Sequencer for layer_mac_sched: pass state, neuron/cycle counters, memory addresses
// and per-cycle phase strobes for the shared multiplier/adder datapath.
module layer_mac_fsm
    import layer_mac_sched_pkg::*;
#(
    parameter int N_IN  = 10,
    parameter int N_OUT = 10,
    parameter int AW    = 8,
    parameter int IW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] act_addr,
    output logic [AW-1:0] w_addr,
    output logic [IW-1:0] n_idx,
    output logic          mul_en,
    output logic          first_en,
    output logic          acc_en,
    output logic          bias_en,
    output logic          emit_en
);

    localparam int P  = N_IN + 3;
    localparam int CW = $clog2(P);

    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [CW-1:0] C_FIRST    = CW'(2);
    localparam logic [CW-1:0] C_ACC0     = CW'(3);
    localparam logic [CW-1:0] C_ACT_LAST = CW'(N_IN - 1);
    localparam logic [CW-1:0] C_MUL_LAST = CW'(N_IN);
    localparam logic [CW-1:0] C_BIAS     = CW'(N_IN + 1);
    localparam logic [CW-1:0] C_LAST     = CW'(N_IN + 2);
    localparam logic [IW-1:0] N_LAST     = IW'(N_OUT - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic [IW-1:0] n_q, n_d;
    logic [AW-1:0] act_addr_q, act_addr_d;
    logic [AW-1:0] w_addr_q, w_addr_d;
    logic          done_q, done_d;
    logic          run_s;

    // Next-state: counters advance every RUN cycle; addresses stop once the bias word is issued.
    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        n_d        = n_q;
        act_addr_d = act_addr_q;
        w_addr_d   = w_addr_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    c_d        = '0;
                    n_d        = '0;
                    act_addr_d = '0;
                    w_addr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (c_q == C_LAST) begin
                    c_d        = '0;
                    act_addr_d = '0;
                    if (n_q == N_LAST) begin
                        state_d  = ST_IDLE;
                        n_d      = '0;
                        w_addr_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        n_d      = n_q + IW'(1);
                        w_addr_d = w_addr_q + AW'(1);
                    end
                end else begin
                    c_d = c_q + CW'(1);
                    if (c_q < C_ACT_LAST) begin
                        act_addr_d = act_addr_q + AW'(1);
                    end else begin
                        act_addr_d = act_addr_q;
                    end
                    if (c_q < C_MUL_LAST) begin
                        w_addr_d = w_addr_q + AW'(1);
                    end else begin
                        w_addr_d = w_addr_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            c_q        <= '0;
            n_q        <= '0;
            act_addr_q <= '0;
            w_addr_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            n_q        <= n_d;
            act_addr_q <= act_addr_d;
            w_addr_q   <= w_addr_d;
            done_q     <= done_d;
        end
    end

    // Phase strobes decoded from the registered cycle counter.
    always_comb begin
        run_s    = (state_q == ST_RUN);
        mul_en   = run_s && (c_q >= C_ONE) && (c_q <= C_MUL_LAST);
        first_en = run_s && (c_q == C_FIRST);
        acc_en   = run_s && (c_q >= C_ACC0) && (c_q <= C_BIAS);
        bias_en  = run_s && (c_q == C_BIAS);
        emit_en  = run_s && (c_q == C_LAST);
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;
    assign act_addr = act_addr_q;
    assign w_addr   = w_addr_q;
    assign n_idx    = n_q;

endmodule

// File: rtl/layer_mac_sched.sv
// One fully-connected ReLU layer computed with a single shared float_mult and float_adder;
// the parent provides both units and the activation/weight memories.
module layer_mac_sched
    import layer_mac_sched_pkg::*;
#(
    parameter int N_IN  = 10,
    parameter int N_OUT = 10,
    parameter int AW    = 8,
    parameter int IW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] act_addr,
    input  logic [31:0]   act_data,
    output logic [AW-1:0] w_addr,
    input  logic [31:0]   w_data,
    output logic [31:0]   mul_x,
    output logic [31:0]   mul_y,
    input  logic [31:0]   mul_z,
    output logic [31:0]   add_a,
    output logic [31:0]   add_b,
    input  logic [31:0]   add_out,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    output logic [31:0]   out_data
);

    logic          mul_en_s, first_en_s, acc_en_s, bias_en_s, emit_en_s;
    logic [IW-1:0] n_idx_s;

    logic [31:0]   prod_q, prod_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   bias_q, bias_d;
    logic          out_valid_q, out_valid_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic [31:0]   out_data_q, out_data_d;

    layer_mac_fsm #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .AW    (AW),
        .IW    (IW)
    ) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .act_addr (act_addr),
        .w_addr   (w_addr),
        .n_idx    (n_idx_s),
        .mul_en   (mul_en_s),
        .first_en (first_en_s),
        .acc_en   (acc_en_s),
        .bias_en  (bias_en_s),
        .emit_en  (emit_en_s)
    );

    // Operand muxes: multiplier idles at +0.0 so its inputs are never X outside product cycles.
    always_comb begin
        if (mul_en_s) begin
            mul_x = act_data;
            mul_y = w_data;
        end else begin
            mul_x = FP_ZERO;
            mul_y = FP_ZERO;
        end
        add_a = acc_q;
        if (emit_en_s) begin
            add_b = bias_q;
        end else begin
            add_b = prod_q;
        end
    end

    // Datapath next-state; the first product loads the accumulator directly.
    always_comb begin
        prod_d      = prod_q;
        acc_d       = acc_q;
        bias_d      = bias_q;
        out_valid_d = emit_en_s;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        if (mul_en_s) begin
            prod_d = mul_z;
        end else begin
            prod_d = prod_q;
        end
        if (first_en_s) begin
            acc_d = prod_q;
        end else if (acc_en_s) begin
            acc_d = add_out;
        end else begin
            acc_d = acc_q;
        end
        if (bias_en_s) begin
            bias_d = w_data;
        end else begin
            bias_d = bias_q;
        end
        if (emit_en_s) begin
            out_data_d = relu_f32(add_out);
            out_idx_d  = n_idx_s;
        end else begin
            out_data_d = out_data_q;
            out_idx_d  = out_idx_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q      <= FP_ZERO;
            acc_q       <= FP_ZERO;
            bias_q      <= FP_ZERO;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= FP_ZERO;
        end else begin
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            bias_q      <= bias_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_layer_mac_sched.sv
// Bench for layer_mac_sched: default 10x10 build plus a 2-input/1-neuron build, with
// behavioural float units, synchronous memories and a dot-product reference model.
module tb_layer_mac_sched;

    localparam int N_IN  = 10;
    localparam int N_OUT = 10;
    localparam int AW    = 8;
    localparam int IW    = 4;
    localparam int P     = N_IN + 3;
    localparam int LAST  = N_OUT * P + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, out_valid;
    logic [AW-1:0] act_addr, w_addr;
    logic [31:0]   act_data = 32'h0, w_data = 32'h0;
    logic [31:0]   mul_x, mul_y, mul_z, add_a, add_b, add_out, out_data;
    logic [IW-1:0] out_idx;

    logic          start2 = 1'b0;
    logic          busy2, done2, out_valid2;
    logic [AW-1:0] act_addr2, w_addr2;
    logic [31:0]   act_data2 = 32'h0, w_data2 = 32'h0;
    logic [31:0]   mul_x2, mul_y2, mul_z2, add_a2, add_b2, add_out2, out_data2;
    logic [IW-1:0] out_idx2;

    logic [31:0] act_mem  [256];
    logic [31:0] w_mem    [256];
    logic [31:0] act2_mem [256];
    logic [31:0] w2_mem   [256];
    logic [31:0] exp_data [N_OUT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        logic [63:0] d;
        e = {3'b000, f[30:23]} + 11'd896;
        if (f[30:23] == 8'd0) d = {f[31], 63'd0};
        else                  d = {f[31], e, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    // Reference: ReLU(sum_k act[k]*w[n][k] + bias[n]) accumulated in index order.
    function automatic logic [31:0] model_neuron(input int n);
        logic [31:0] acc;
        int base;
        base = n * (N_IN + 1);
        acc = fmul(act_mem[0], w_mem[base]);
        for (int k = 1; k < N_IN; k++) acc = fadd(acc, fmul(act_mem[k], w_mem[base + k]));
        acc = fadd(acc, w_mem[base + N_IN]);
        return acc[31] ? 32'h0 : acc;
    endfunction

    function automatic logic [31:0] rnd_f();
        int v;
        v = int'($urandom_range(0, 16));
        return r2f(real'(v - 8) / 2.0);
    endfunction

    always_comb begin
        mul_z    = fmul(mul_x, mul_y);
        add_out  = fadd(add_a, add_b);
        mul_z2   = fmul(mul_x2, mul_y2);
        add_out2 = fadd(add_a2, add_b2);
    end

    always @(posedge clk) begin
        act_data  <= act_mem[act_addr];
        w_data    <= w_mem[w_addr];
        act_data2 <= act2_mem[act_addr2];
        w_data2   <= w2_mem[w_addr2];
    end

    layer_mac_sched #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW), .IW(IW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .act_addr(act_addr), .act_data(act_data), .w_addr(w_addr), .w_data(w_data),
        .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
        .add_a(add_a), .add_b(add_b), .add_out(add_out),
        .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data)
    );

    layer_mac_sched #(.N_IN(2), .N_OUT(1), .AW(AW), .IW(IW)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .act_addr(act_addr2), .act_data(act_data2), .w_addr(w_addr2), .w_data(w_data2),
        .mul_x(mul_x2), .mul_y(mul_y2), .mul_z(mul_z2),
        .add_a(add_a2), .add_b(add_b2), .add_out(add_out2),
        .out_valid(out_valid2), .out_idx(out_idx2), .out_data(out_data2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic load_mem(input logic [31:0] a, input logic [31:0] w, input logic [31:0] b);
        for (int i = 0; i < 256; i++) begin
            act_mem[i] = 32'h0;
            w_mem[i]   = 32'h0;
        end
        for (int k = 0; k < N_IN; k++) act_mem[k] = a;
        for (int n = 0; n < N_OUT; n++) begin
            for (int k = 0; k < N_IN; k++) w_mem[n * (N_IN + 1) + k] = w;
            w_mem[n * (N_IN + 1) + N_IN] = b;
        end
    endtask

    // Launches a pass and checks every cycle against the timing rules; optional mid-pass
    // start pulses, a one-cycle reset at cycle rst_at, or start held high throughout.
    task automatic run_pass(input bit pulse_starts, input int rst_at, input bit hold_start);
        int  j, nv, c, n;
        bit  aborted, exp_ov;
        j = 0; nv = 0; aborted = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = hold_start;
        for (int k = 1; k <= LAST; k++) begin
            @(negedge clk);
            c = (k - 1) % P;
            n = (k - 1) / P;
            if (aborted) begin
                check_val($sformatf("busy_after_rst c%0d", k), 32'(busy), 32'h0);
                check_val($sformatf("ov_after_rst c%0d", k), 32'(out_valid), 32'h0);
            end else begin
                exp_ov = (k > P) && (c == 0);
                check_val($sformatf("busy c%0d", k), 32'(busy), 32'(k <= N_OUT * P));
                check_val($sformatf("out_valid c%0d", k), 32'(out_valid), 32'(exp_ov));
                check_val($sformatf("done c%0d", k), 32'(done), 32'(k == LAST));
                if (out_valid) nv++;
                if (exp_ov) begin
                    check_val($sformatf("out_idx c%0d", k), 32'(out_idx), 32'(n - 1));
                    check_val($sformatf("out_data n%0d", n - 1), out_data, exp_data[n - 1]);
                end
                if (k <= N_OUT * P && c <= N_IN) begin
                    check_val($sformatf("w_addr c%0d", k), 32'(w_addr), 32'(j));
                    j++;
                    if (c < N_IN) check_val($sformatf("act_addr c%0d", k), 32'(act_addr), 32'(c));
                end
            end
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_val("rst busy", 32'(busy), 32'h0);
                check_val("rst out_valid", 32'(out_valid), 32'h0);
                check_val("rst done", 32'(done), 32'h0);
                aborted = 1'b1;
            end else if (rst_at > 0 && k == rst_at + 1) begin
                rst_n = 1'b1;
            end
            start = hold_start | (pulse_starts && (k == 5 || k == 60));
        end
        if (!aborted) check_val("pulse_count", 32'(nv), 32'(N_OUT));
    endtask

    initial begin
        int nv;
        bit seen_done;
        load_mem(32'h4000_0000, 32'h3F80_0000, 32'h3F00_0000);
        for (int i = 0; i < 256; i++) begin
            act2_mem[i] = 32'h0;
            w2_mem[i]   = 32'h0;
        end
        act2_mem[0] = 32'h3F80_0000;
        act2_mem[1] = 32'h4040_0000;
        w2_mem[0]   = 32'h4000_0000;
        w2_mem[1]   = 32'hBF80_0000;
        w2_mem[2]   = 32'h0000_0000;

        repeat (3) @(negedge clk);
        check_val("reset busy", 32'(busy), 32'h0);
        check_val("reset done", 32'(done), 32'h0);
        check_val("reset out_valid", 32'(out_valid), 32'h0);
        check_val("reset out_data", out_data, 32'h0);
        check_val("reset out_idx", 32'(out_idx), 32'h0);
        check_val("reset w_addr", 32'(w_addr), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2.0 * 1.0 * 10 + 0.5 = 20.5 for every neuron.
        for (int n = 0; n < N_OUT; n++) exp_data[n] = 32'h41A4_0000;
        run_pass(1'b0, 0, 1'b0);

        // Negative sums clamp to zero; neuron 3 bias 25.25 gives 5.25.
        load_mem(32'h4000_0000, 32'hBF80_0000, 32'h3F00_0000);
        w_mem[3 * (N_IN + 1) + N_IN] = 32'h41CA_0000;
        for (int n = 0; n < N_OUT; n++) exp_data[n] = 32'h0;
        exp_data[3] = 32'h40A8_0000;
        run_pass(1'b1, 0, 1'b0);

        // Start held high: ignored during the pass, relaunches from IDLE on the done cycle.
        load_mem(32'h4000_0000, 32'h3F80_0000, 32'h3F00_0000);
        for (int n = 0; n < N_OUT; n++) exp_data[n] = 32'h41A4_0000;
        run_pass(1'b0, 0, 1'b1);
        @(negedge clk);
        check_val("relaunch busy c132", 32'(busy), 32'h1);
        start = 1'b0;
        nv = 0;
        seen_done = 1'b0;
        for (int t = 0; t < 2 * LAST && !seen_done; t++) begin
            @(negedge clk);
            if (out_valid) nv++;
            if (done) seen_done = 1'b1;
        end
        check_val("relaunch done seen", 32'(seen_done), 32'h1);
        check_val("relaunch pulse_count", 32'(nv), 32'(N_OUT));

        // Reset during neuron 2's output cycle, then a clean pass.
        run_pass(1'b0, 40, 1'b0);
        run_pass(1'b0, 0, 1'b0);

        // Randomized weights/activations against the reference model.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N_OUT * (N_IN + 1); i++) w_mem[i] = rnd_f();
            for (int k = 0; k < N_IN; k++) act_mem[k] = rnd_f();
            for (int n = 0; n < N_OUT; n++) exp_data[n] = model_neuron(n);
            run_pass(1'b0, 0, 1'b0);
        end

        // Minimal build: 1*2 + 3*(-1) + 0 = -1.0, clamped; done in cycle 6.
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check_val($sformatf("small busy c%0d", k), 32'(busy2), 32'(k <= 5));
            check_val($sformatf("small done c%0d", k), 32'(done2), 32'(k == 6));
            check_val($sformatf("small out_valid c%0d", k), 32'(out_valid2), 32'(k == 6));
            if (k == 6) begin
                check_val("small out_data", out_data2, 32'h0);
                check_val("small out_idx", 32'(out_idx2), 32'h0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
